// File: rtl/bp_be_late_wb_arbiter_if.sv
// Late-writeback arbiter bus: requester side and regfile-writeback side.
// Latency: none (wiring only).
// Backpressure: req_ready_o per requester, wb_ready_i from the regfile write mux.
//
// Signals
//   req_v_i/req_ready_o   per-requester valid / one-hot grant
//   req_fp_i              per-requester fp-destination flag
//   req_rd_i              packed rd addresses, requester i at [i*reg_addr_width_p +: reg_addr_width_p]
//   req_data_i            packed results, requester i at [i*data_width_p +: data_width_p]
//   req_fflags_i          packed fflags, requester i at [i*5 +: 5]
//   wb_*                  registered writeback packet towards the regfiles
//   conflict_cnt_o        packed per-requester lost-arbitration counters
// Modports: slave = the arbiter, master = producers plus regfile side (the environment).
interface bp_be_late_wb_arbiter_if #(
  parameter int num_req_p        = 3,
  parameter int data_width_p     = 64,
  parameter int reg_addr_width_p = 5,
  parameter int cnt_width_p      = 16
);
  logic [num_req_p-1:0]                  req_v_i;
  logic [num_req_p-1:0]                  req_ready_o;
  logic [num_req_p-1:0]                  req_fp_i;
  logic [num_req_p*reg_addr_width_p-1:0] req_rd_i;
  logic [num_req_p*data_width_p-1:0]     req_data_i;
  logic [num_req_p*5-1:0]                req_fflags_i;

  logic                                  wb_v_o;
  logic                                  wb_ready_i;
  logic                                  wb_ird_w_o;
  logic                                  wb_frd_w_o;
  logic                                  wb_late_o;
  logic [reg_addr_width_p-1:0]           wb_rd_o;
  logic [data_width_p-1:0]               wb_data_o;
  logic [4:0]                            wb_fflags_o;

  logic [num_req_p*cnt_width_p-1:0]      conflict_cnt_o;

  modport slave (
    input  req_v_i, req_fp_i, req_rd_i, req_data_i, req_fflags_i, wb_ready_i,
    output req_ready_o, wb_v_o, wb_ird_w_o, wb_frd_w_o, wb_late_o,
           wb_rd_o, wb_data_o, wb_fflags_o, conflict_cnt_o
  );

  modport master (
    output req_v_i, req_fp_i, req_rd_i, req_data_i, req_fflags_i, wb_ready_i,
    input  req_ready_o, wb_v_o, wb_ird_w_o, wb_frd_w_o, wb_late_o,
           wb_rd_o, wb_data_o, wb_fflags_o, conflict_cnt_o
  );
endinterface

// File: rtl/bp_be_late_wb_arbiter.sv
// Shares the single late-writeback regfile port among long-latency producers (round-robin + starvation override).
// Latency: grant in cycle N -> registered packet on wb_* in cycle N+1; one packet per cycle sustained.
// Backpressure: while wb_v_o & ~wb_ready_i the packet is held stable and no requester is granted.
//
// Ports
//   clk_i      rising-edge clock
//   reset_n_i  asynchronous active-low reset (assert async, deassert synchronised internally)
//   io         bp_be_late_wb_arbiter_if.slave: requester handshake, writeback packet, perf counters
// Build option
//   BP_BE_LATE_WB_PERF_EN  when defined, builds the per-requester lost-arbitration counters;
//                          otherwise conflict_cnt_o is tied to zero.
module bp_be_late_wb_arbiter #(
  parameter int num_req_p        = 3,
  parameter int data_width_p     = 64,
  parameter int reg_addr_width_p = 5,
  parameter int max_wait_p       = 8,
  parameter int cnt_width_p      = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bp_be_late_wb_arbiter_if.slave      io
);

  localparam int idx_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int wait_w = $clog2(max_wait_p + 1);

  localparam logic [idx_w-1:0]  last_idx = idx_w'(num_req_p - 1);
  localparam logic [wait_w-1:0] wait_max = wait_w'(max_wait_p);

  // ------------------------------------------------------------------
  // Reset synchroniser: assertion reaches every flop immediately, release
  // is aligned to clk_i so state leaves reset on a clean edge.
  // ------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // ------------------------------------------------------------------
  // Unpack requester buses
  // ------------------------------------------------------------------
  logic [reg_addr_width_p-1:0] rd_a     [num_req_p];
  logic [data_width_p-1:0]     data_a   [num_req_p];
  logic [4:0]                  fflags_a [num_req_p];

  for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
    assign rd_a[g]     = io.req_rd_i[g*reg_addr_width_p +: reg_addr_width_p];
    assign data_a[g]   = io.req_data_i[g*data_width_p +: data_width_p];
    assign fflags_a[g] = io.req_fflags_i[g*5 +: 5];
  end

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [idx_w-1:0]            rr_ptr_q;
  logic [wait_w-1:0]           wait_q [num_req_p];

  logic                        wb_v_q;
  logic                        wb_fp_q;
  logic [reg_addr_width_p-1:0] wb_rd_q;
  logic [data_width_p-1:0]     wb_data_q;
  logic [4:0]                  wb_fflags_q;

  // ------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------
  logic                        slot_free;
  logic                        starve_hit;
  logic [idx_w-1:0]            starve_idx;
  logic                        hi_hit;
  logic [idx_w-1:0]            hi_idx;
  logic                        lo_hit;
  logic [idx_w-1:0]            lo_idx;
  logic                        gnt_vld;
  logic [idx_w-1:0]            gnt_idx;
  logic [num_req_p-1:0]        gnt_oh;

  // The output register can take a new packet when empty or draining this cycle.
  assign slot_free = ~wb_v_q | io.wb_ready_i;

  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    hi_hit     = 1'b0;
    hi_idx     = '0;
    lo_hit     = 1'b0;
    lo_idx     = '0;

    // Scanning downwards lets the lowest matching index overwrite the rest.
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (io.req_v_i[i] && (wait_q[i] == wait_max)) begin
        starve_hit = 1'b1;
        starve_idx = idx_w'(i);
      end
      // Round-robin split into two ranges: [rr_ptr, N) first, else wrap to [0, rr_ptr).
      if (io.req_v_i[i] && (idx_w'(i) >= rr_ptr_q)) begin
        hi_hit = 1'b1;
        hi_idx = idx_w'(i);
      end
      if (io.req_v_i[i]) begin
        lo_hit = 1'b1;
        lo_idx = idx_w'(i);
      end
    end

    gnt_vld = rst_n & slot_free & (starve_hit | hi_hit | lo_hit);

    if (starve_hit) begin
      gnt_idx = starve_idx;
    end else if (hi_hit) begin
      gnt_idx = hi_idx;
    end else begin
      gnt_idx = lo_idx;
    end

    for (int i = 0; i < num_req_p; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_idx == idx_w'(i));
    end
  end

  // A grant always lands on a valid requester, so the grant vector is the transfer vector.
  assign io.req_ready_o = gnt_oh;

  // ------------------------------------------------------------------
  // Granted-packet mux
  // ------------------------------------------------------------------
  logic                        sel_fp;
  logic [reg_addr_width_p-1:0] sel_rd;
  logic [data_width_p-1:0]     sel_data;
  logic [4:0]                  sel_fflags;

  always_comb begin
    sel_fp     = 1'b0;
    sel_rd     = '0;
    sel_data   = '0;
    sel_fflags = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (gnt_idx == idx_w'(i)) begin
        sel_fp     = io.req_fp_i[i];
        sel_rd     = rd_a[i];
        sel_data   = data_a[i];
        sel_fflags = fflags_a[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Round-robin pointer: moves only on a transfer, to one past the winner.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (gnt_vld) begin
      rr_ptr_q <= (gnt_idx == last_idx) ? '0 : gnt_idx + 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Wait counters: count ungranted valid cycles (hold cycles included),
  // saturate at the threshold, clear on grant or when idle.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < num_req_p; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        if (!io.req_v_i[i] || gnt_oh[i]) begin
          wait_q[i] <= '0;
        end else if (wait_q[i] != wait_max) begin
          wait_q[i] <= wait_q[i] + 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Output register: loading a new packet while the old one drains is legal,
  // giving one packet per cycle. fflags are zeroed for int destinations here
  // so the held packet needs no further masking.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wb_v_q      <= 1'b0;
      wb_fp_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_fflags_q <= '0;
    end else if (gnt_vld) begin
      wb_v_q      <= 1'b1;
      wb_fp_q     <= sel_fp;
      wb_rd_q     <= sel_rd;
      wb_data_q   <= sel_data;
      wb_fflags_q <= sel_fp ? sel_fflags : 5'b0;
    end else if (io.wb_ready_i) begin
      wb_v_q      <= 1'b0;
    end
  end

  assign io.wb_v_o      = wb_v_q;
  assign io.wb_ird_w_o  = wb_v_q & ~wb_fp_q;
  assign io.wb_frd_w_o  = wb_v_q &  wb_fp_q;
  // Late flag tells the issue scoreboard to clear rd on this same write.
  assign io.wb_late_o   = wb_v_q;
  assign io.wb_rd_o     = wb_rd_q;
  assign io.wb_data_o   = wb_data_q;
  assign io.wb_fflags_o = wb_fflags_q;

  // ------------------------------------------------------------------
  // Lost-arbitration counters
  // ------------------------------------------------------------------
`ifdef BP_BE_LATE_WB_PERF_EN
  logic [cnt_width_p-1:0] cnt_q [num_req_p];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < num_req_p; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        if (io.req_v_i[i] && !gnt_oh[i] && (cnt_q[i] != {cnt_width_p{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < num_req_p; g++) begin : g_cnt_pack
    assign io.conflict_cnt_o[g*cnt_width_p +: cnt_width_p] = cnt_q[g];
  end
`else
  assign io.conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Scenario bench for the late-writeback arbiter: a bench-side model predicts each cycle's grant
// and queues the expected writeback packet; packets are popped and compared as the regfile side drains them.
module tb_bp_be_late_wb_arbiter;
  localparam int NR = 3;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int MW = 2;
`ifdef BP_BE_LATE_WB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_be_late_wb_arbiter_if #(.num_req_p(NR), .data_width_p(DW), .reg_addr_width_p(AW), .cnt_width_p(CW)) bus ();

  bp_be_late_wb_arbiter #(
    .num_req_p(NR), .data_width_p(DW), .reg_addr_width_p(AW), .max_wait_p(MW), .cnt_width_p(CW)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .io        (bus)
  );

  // Producer-side payload registers
  logic [NR-1:0] r_fp;
  logic [AW-1:0] r_rd   [NR];
  logic [DW-1:0] r_data [NR];
  logic [4:0]    r_ff   [NR];

  assign bus.req_fp_i     = r_fp;
  assign bus.req_rd_i     = {r_rd[2], r_rd[1], r_rd[0]};
  assign bus.req_data_i   = {r_data[2], r_data[1], r_data[0]};
  assign bus.req_fflags_i = {r_ff[2], r_ff[1], r_ff[0]};

  typedef struct packed {
    logic          ird;
    logic          frd;
    logic          late;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic [4:0]    ff;
  } pkt_t;

  pkt_t q[$];
  int   m_rr;
  int   m_wait [NR];
  int   m_cnt  [NR];
  int   checks = 0;
  int   errors = 0;

  function automatic pkt_t obs();
    pkt_t p;
    p.ird  = bus.wb_ird_w_o;
    p.frd  = bus.wb_frd_w_o;
    p.late = bus.wb_late_o;
    p.rd   = bus.wb_rd_o;
    p.data = bus.wb_data_o;
    p.ff   = bus.wb_fflags_o;
    return p;
  endfunction

  function automatic logic [NR-1:0] exp_cnt_vec_slice(input int i);
    return '0;
  endfunction

  // Expected grant for the current inputs and model state.
  function automatic logic [NR-1:0] m_grant();
    logic [NR-1:0] v;
    logic [NR-1:0] one;
    int idx;
    v   = bus.req_v_i;
    one = 1;
    if (!(q.size() == 0 || bus.wb_ready_i)) return '0;
    for (int i = 0; i < NR; i++)
      if (v[i] && m_wait[i] == MW) return one << i;
    for (int k = 0; k < NR; k++) begin
      idx = (m_rr + k) % NR;
      if (v[idx]) return one << idx;
    end
    return '0;
  endfunction

  // Advance the model across one rising edge given the predicted grant.
  task automatic m_update(input logic [NR-1:0] g);
    pkt_t p;
    logic [NR-1:0] v;
    v = bus.req_v_i;
    if (q.size() != 0 && bus.wb_ready_i) void'(q.pop_front());
    for (int i = 0; i < NR; i++) begin
      if (g[i]) begin
        p.ird  = ~r_fp[i];
        p.frd  = r_fp[i];
        p.late = 1'b1;
        p.rd   = r_rd[i];
        p.data = r_data[i];
        p.ff   = r_fp[i] ? r_ff[i] : 5'h0;
        q.push_back(p);
        m_rr = (i + 1) % NR;
      end
      if (!v[i] || g[i]) m_wait[i] = 0;
      else if (m_wait[i] < MW) m_wait[i]++;
      if (v[i] && !g[i]) m_cnt[i]++;
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_rr = 0;
    for (int i = 0; i < NR; i++) begin
      m_wait[i] = 0;
      m_cnt[i]  = 0;
    end
  endtask

  function automatic logic [NR*CW-1:0] exp_cnt();
    logic [NR*CW-1:0] e;
    e = '0;
    if (PERF)
      for (int i = 0; i < NR; i++) e[i*CW +: CW] = CW'(m_cnt[i]);
    return e;
  endfunction

  task automatic set_req(input int i, input logic fp, input logic [AW-1:0] rd,
                         input logic [DW-1:0] data, input logic [4:0] ff);
    r_fp[i] = fp; r_rd[i] = rd; r_data[i] = data; r_ff[i] = ff;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_v_i = '0;
    bus.wb_ready_i = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0, '0);
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.wb_v_o !== 1'b0 || bus.req_ready_o !== '0) begin
      errors++; $display("FAIL reset_vld: wb_v=%b ready=%b expected 0/000", bus.wb_v_o, bus.req_ready_o);
    end
    checks++;
    if (obs() !== pkt_t'(0)) begin
      errors++; $display("FAIL reset_pkt: got %h expected 0", obs());
    end
    checks++;
    if (bus.conflict_cnt_o !== '0) begin
      errors++; $display("FAIL reset_cnt: got %h expected 0", bus.conflict_cnt_o);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Single int requester: grant in cycle 0, packet in cycle 1.
  task automatic test_single();
    logic [NR-1:0] eg;
    logic [NR-1:0] tv [3] = '{3'b001, 3'b000, 3'b000};
    set_req(0, 1'b0, 5'd5, 64'hA5, 5'h1f);
    bus.wb_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.req_v_i = tv[c];
      @(negedge clk);
      eg = m_grant();
      checks++;
      if (bus.req_ready_o !== eg) begin errors++; $display("FAIL single_grant c%0d: ready=%b expected %b", c, bus.req_ready_o, eg); end
      checks++;
      if (bus.wb_v_o !== (q.size() != 0)) begin errors++; $display("FAIL single_vld c%0d: wb_v=%b expected %b", c, bus.wb_v_o, q.size() != 0); end
      if (q.size() != 0) begin
        checks++;
        if (obs() !== q[0]) begin errors++; $display("FAIL single_pkt c%0d: got %h expected %h", c, obs(), q[0]); end
      end
      if (c == 0) begin
        checks++;
        if (bus.req_ready_o !== 3'b001) begin errors++; $display("FAIL single_first_grant: ready=%b expected 001", bus.req_ready_o); end
      end
      if (c == 1) begin
        checks++;
        if (obs() !== {1'b1, 1'b0, 1'b1, 5'd5, 64'hA5, 5'h0} || bus.wb_v_o !== 1'b1) begin
          errors++; $display("FAIL single_first_pkt: got %h v=%b expected int rd5 data A5 late", obs(), bus.wb_v_o);
        end
      end
      m_update(eg);
      @(posedge clk); #1;
    end
  endtask

  // All three requesters held valid: one grant per cycle, rotating and wrapping.
  task automatic test_back_to_back();
    logic [NR-1:0] eg;
    int n2 = 0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i + 8), DW'(64'h1000 + i), 5'h0);
    bus.wb_ready_i = 1'b1;
    bus.req_v_i = 3'b111;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      eg = m_grant();
      checks++;
      if (bus.req_ready_o !== eg) begin errors++; $display("FAIL b2b_grant c%0d: ready=%b expected %b", c, bus.req_ready_o, eg); end
      checks++;
      if (bus.wb_v_o !== (q.size() != 0)) begin errors++; $display("FAIL b2b_vld c%0d: wb_v=%b expected %b", c, bus.wb_v_o, q.size() != 0); end
      if (q.size() != 0) begin
        checks++;
        if (obs() !== q[0]) begin errors++; $display("FAIL b2b_pkt c%0d: got %h expected %h", c, obs(), q[0]); end
      end
      if (eg == 3'b100) n2++;
      m_update(eg);
      @(posedge clk); #1;
      // A granted producer presents its next result.
      for (int i = 0; i < NR; i++) if (eg[i]) r_data[i] = r_data[i] + 64'h100;
    end
    checks++;
    if (n2 != 3) begin errors++; $display("FAIL b2b_rotation: req2 grants %0d expected 3", n2); end
    bus.req_v_i = '0;
    @(negedge clk); m_update(m_grant()); @(posedge clk); #1;
  endtask

  // Output held for 4 cycles, then released: req 1 wins in the release cycle.
  task automatic test_hold();
    logic [NR-1:0] eg;
    logic [NR-1:0] tv [8] = '{3'b001, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b100, 3'b000};
    logic          tr [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    set_req(0, 1'b0, 5'd7,  64'hDEAD_0000, 5'h0);
    set_req(1, 1'b0, 5'd0,  64'h1111,      5'h0);
    set_req(2, 1'b0, 5'd31, 64'h2222,      5'h0);
    for (int c = 0; c < 8; c++) begin
      bus.req_v_i = tv[c];
      bus.wb_ready_i = tr[c];
      @(negedge clk);
      eg = m_grant();
      checks++;
      if (bus.req_ready_o !== eg) begin errors++; $display("FAIL hold_grant c%0d: ready=%b expected %b", c, bus.req_ready_o, eg); end
      checks++;
      if (bus.wb_v_o !== (q.size() != 0)) begin errors++; $display("FAIL hold_vld c%0d: wb_v=%b expected %b", c, bus.wb_v_o, q.size() != 0); end
      if (q.size() != 0) begin
        checks++;
        if (obs() !== q[0]) begin errors++; $display("FAIL hold_pkt c%0d: got %h expected %h", c, obs(), q[0]); end
      end
      if (c == 5) begin
        checks++;
        if (bus.req_ready_o !== 3'b010) begin errors++; $display("FAIL hold_release: ready=%b expected 010", bus.req_ready_o); end
      end
      m_update(eg);
      @(posedge clk); #1;
    end
  endtask

  // Req 2 starves behind output hold; at the threshold it beats rr's choice of req 1.
  task automatic test_starvation();
    logic [NR-1:0] eg;
    logic [NR-1:0] tv [7] = '{3'b001, 3'b100, 3'b100, 3'b110, 3'b010, 3'b000, 3'b000};
    logic          tr [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    set_req(0, 1'b0, 5'd1, 64'hAAAA, 5'h0);
    set_req(1, 1'b0, 5'd2, 64'hBBBB, 5'h0);
    set_req(2, 1'b1, 5'd3, 64'hCCCC, 5'h03);
    for (int c = 0; c < 7; c++) begin
      bus.req_v_i = tv[c];
      bus.wb_ready_i = tr[c];
      @(negedge clk);
      eg = m_grant();
      checks++;
      if (bus.req_ready_o !== eg) begin errors++; $display("FAIL starve_grant c%0d: ready=%b expected %b", c, bus.req_ready_o, eg); end
      checks++;
      if (bus.wb_v_o !== (q.size() != 0)) begin errors++; $display("FAIL starve_vld c%0d: wb_v=%b expected %b", c, bus.wb_v_o, q.size() != 0); end
      if (q.size() != 0) begin
        checks++;
        if (obs() !== q[0]) begin errors++; $display("FAIL starve_pkt c%0d: got %h expected %h", c, obs(), q[0]); end
      end
      if (c == 3) begin
        checks++;
        if (bus.req_ready_o !== 3'b100) begin errors++; $display("FAIL starve_forced: ready=%b expected 100", bus.req_ready_o); end
      end
      if (c == 4) begin
        checks++;
        if (bus.req_ready_o !== 3'b010) begin errors++; $display("FAIL starve_after: ready=%b expected 010", bus.req_ready_o); end
      end
      m_update(eg);
      @(posedge clk); #1;
    end
  endtask

  // fp write carries fflags; int write forces fflags to 0 regardless of input.
  task automatic test_fp();
    logic [NR-1:0] eg;
    logic [NR-1:0] tv [4] = '{3'b010, 3'b001, 3'b000, 3'b000};
    set_req(1, 1'b1, 5'd3, 64'h3FF0_0000_0000_0000, 5'h10);
    set_req(0, 1'b0, 5'd9, 64'h99, 5'h1f);
    bus.wb_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.req_v_i = tv[c];
      @(negedge clk);
      eg = m_grant();
      checks++;
      if (bus.req_ready_o !== eg) begin errors++; $display("FAIL fp_grant c%0d: ready=%b expected %b", c, bus.req_ready_o, eg); end
      checks++;
      if (bus.wb_v_o !== (q.size() != 0)) begin errors++; $display("FAIL fp_vld c%0d: wb_v=%b expected %b", c, bus.wb_v_o, q.size() != 0); end
      if (q.size() != 0) begin
        checks++;
        if (obs() !== q[0]) begin errors++; $display("FAIL fp_pkt c%0d: got %h expected %h", c, obs(), q[0]); end
      end
      if (c == 1) begin
        checks++;
        if (bus.wb_frd_w_o !== 1'b1 || bus.wb_ird_w_o !== 1'b0 || bus.wb_fflags_o !== 5'h10) begin
          errors++; $display("FAIL fp_write: frd=%b ird=%b ff=%h expected 1/0/10", bus.wb_frd_w_o, bus.wb_ird_w_o, bus.wb_fflags_o);
        end
      end
      if (c == 2) begin
        checks++;
        if (bus.wb_ird_w_o !== 1'b1 || bus.wb_fflags_o !== 5'h0) begin
          errors++; $display("FAIL int_fflags: ird=%b ff=%h expected 1/00", bus.wb_ird_w_o, bus.wb_fflags_o);
        end
      end
      m_update(eg);
      @(posedge clk); #1;
    end
  endtask

  // Three lost cycles for req 1 under hold, then async reset in mid-hold.
  task automatic test_perf_and_async_reset();
    logic [NR-1:0] eg;
    logic [NR-1:0] tv [4] = '{3'b001, 3'b010, 3'b010, 3'b010};
    logic          tr [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [CW-1:0] c1;
    test_reset();
    set_req(0, 1'b0, 5'd4, 64'h44, 5'h0);
    set_req(1, 1'b0, 5'd6, 64'h66, 5'h0);
    for (int c = 0; c < 4; c++) begin
      bus.req_v_i = tv[c];
      bus.wb_ready_i = tr[c];
      @(negedge clk);
      eg = m_grant();
      checks++;
      if (bus.req_ready_o !== eg) begin errors++; $display("FAIL perf_grant c%0d: ready=%b expected %b", c, bus.req_ready_o, eg); end
      if (q.size() != 0) begin
        checks++;
        if (obs() !== q[0] || bus.wb_v_o !== 1'b1) begin errors++; $display("FAIL perf_pkt c%0d: got %h v=%b expected %h", c, obs(), bus.wb_v_o, q[0]); end
      end
      m_update(eg);
      @(posedge clk); #1;
    end
    c1 = bus.conflict_cnt_o[CW +: CW];
    checks++;
    if (c1 !== (PERF ? CW'(3) : CW'(0))) begin errors++; $display("FAIL perf_cnt1: got %0d expected %0d", c1, PERF ? 3 : 0); end
    checks++;
    if (bus.conflict_cnt_o !== exp_cnt()) begin errors++; $display("FAIL perf_cnt_all: got %h expected %h", bus.conflict_cnt_o, exp_cnt()); end
    // Still holding: drop reset between edges.
    reset_n = 1'b0;
    #2;
    checks++;
    if (bus.wb_v_o !== 1'b0 || bus.req_ready_o !== '0 || bus.conflict_cnt_o !== '0) begin
      errors++; $display("FAIL async_reset: wb_v=%b ready=%b cnt=%h expected 0", bus.wb_v_o, bus.req_ready_o, bus.conflict_cnt_o);
    end
    test_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_starvation();
    test_fp();
    test_perf_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
